// File: rtl/data_ram_resp_if.sv
// Memory-stage load/store bus between the pipeline memory stage (master)
// and the data-memory responder (slave).
interface data_ram_resp_if;
    // Handshake: ce_i is the request valid. While stallreq_o is high the
    // requester holds its request stable. ack_o pulses for one cycle with
    // stallreq_o low, and that cycle is the point where the request is
    // complete and data_o is valid for reads. flush_i aborts any access that
    // has not yet taken place.
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic        flush_i;
    logic [31:0] data_o;
    logic        stallreq_o;
    logic        ack_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i, flush_i,
        input  data_o, stallreq_o, ack_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i, flush_i,
        output data_o, stallreq_o, ack_o
    );
endinterface

// File: rtl/data_ram_resp.sv
// Data-memory responder: one access at a time on a big-endian word array,
// with programmable wait states and a stall request while outstanding.
module data_ram_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    data_ram_resp_if.slave   bus,
    output logic [1:0]       o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic [3:0]            w_next_cnt;
    logic                  w_accept;
    logic                  w_access;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [3:0]            r_sel;
    logic [31:0]           r_wdata;
    logic [31:0]           r_data;
    logic [31:0]           r_mem [DEPTH];

    // Byte offset and address bits above the array size are ignored (aliasing).
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};

    assign w_accept = (r_state == S_IDLE) && bus.ce_i && !bus.flush_i;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_WAIT;
                    w_next_cnt   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (bus.flush_i) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            // DONE ignores ce_i and flush_i: the access has already happened.
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_sel   <= 4'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= bus.we_i;
            r_idx   <= bus.addr_i[ADDR_WIDTH+1:2];
            r_sel   <= bus.sel_i;
            r_wdata <= bus.data_i;
        end
    end

    // Reads return the whole word; the requester picks out its bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= 32'd0;
        end else if (w_access && !r_we) begin
            r_data <= r_mem[r_idx];
        end
    end

    // sel[3] maps to data[31:24], the lowest byte address (big-endian lanes).
    always_ff @(posedge clk) begin
        if (w_access && r_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_sel[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.data_o     = r_data;
    assign bus.stallreq_o = w_accept || (r_state == S_WAIT);
    assign bus.ack_o      = (r_state == S_DONE);
    assign o_dbg_state    = r_state;
endmodule
